// File: rtl/riscv_types.sv
// Shared integer-divide types: operation encoding, FSM state and the
// INT_MIN helper.
package riscv_types;

  localparam int MAX_W = 128;

  typedef enum logic [1:0] {
    OP_DIV  = 2'd0,
    OP_DIVU = 2'd1,
    OP_REM  = 2'd2,
    OP_REMU = 2'd3
  } div_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_t;

  // Most negative two's-complement value for a w-bit word (caller truncates).
  function automatic logic [MAX_W-1:0] int_min(input int w);
    return {{(MAX_W-1){1'b0}}, 1'b1} << (w - 1);
  endfunction

  function automatic logic is_signed_op(input div_op_t op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_rem_op(input div_op_t op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/int_div_step.sv
// Combinational restoring-division slice retiring STEP quotient bits.
// Partial remainder is always below the divisor, so it fits in WIDTH bits.
module int_div_step #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH-1:0] rem_s [STEP+1];
  logic [WIDTH-1:0] quo_s [STEP+1];

  assign rem_s[0] = rem_i;
  assign quo_s[0] = quo_i;

  for (genvar gi = 0; gi < STEP; gi++) begin : g_bit
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    assign shifted = {rem_s[gi], quo_s[gi][WIDTH-1]};
    // diff[WIDTH] set means the trial subtraction borrowed: restore.
    assign diff = shifted - {1'b0, div_i};
    assign rem_s[gi+1] = diff[WIDTH] ? {rem_s[gi][WIDTH-2:0], quo_s[gi][WIDTH-1]}
                                     : diff[WIDTH-1:0];
    assign quo_s[gi+1] = {quo_s[gi][WIDTH-2:0], ~diff[WIDTH]};
  end

  assign rem_o = rem_s[STEP];
  assign quo_o = quo_s[STEP];

endmodule

// File: rtl/int_div_rem_mc.sv
// Multi-cycle integer divide/remainder unit (DIV/DIVU/REM/REMU).
// Optional result cache enabled by macro INT_DIV_RESULT_CACHE_EN.
module int_div_rem_mc
  import riscv_types::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  div_op_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_dbz,
  output logic             out_ovf,
  output logic [TAG_W-1:0] busy_tag
);

  localparam int N = WIDTH / STEP;
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);
  localparam logic [WIDTH-1:0] INT_MIN_C = WIDTH'(int_min(WIDTH));

  if (((WIDTH % STEP) != 0) || !((STEP == 1) || (STEP == 2) || (STEP == 4))) begin : g_bad_step
    $error("int_div_rem_mc: STEP must be 1, 2 or 4 and divide WIDTH");
  end

  div_state_t state_q, state_d;

  logic [WIDTH-1:0] rem_q, quo_q, div_q, res_q;
  logic [WIDTH-1:0] rem_nx, quo_nx;
  logic [CNT_W-1:0] cnt_q;
  logic [TAG_W-1:0] tag_q;
  logic             rem_op_q, q_neg_q, r_neg_q, dbz_q, ovf_q;

  logic             accept, a_neg, b_neg, dbz, ovf, hit;
  logic [WIDTH-1:0] a_abs, b_abs, hit_res, rem_fix, quo_fix;

  assign accept = in_valid && (state_q == S_IDLE) && !flush;
  assign a_neg  = is_signed_op(op) && a[WIDTH-1];
  assign b_neg  = is_signed_op(op) && b[WIDTH-1];
  assign a_abs  = a_neg ? -a : a;
  assign b_abs  = b_neg ? -b : b;
  assign dbz    = (b == '0);
  assign ovf    = is_signed_op(op) && (a == INT_MIN_C) && (b == '1);

  // Remainder follows the dividend's sign; quotient is negative on sign mismatch.
  assign rem_fix = r_neg_q ? -rem_q : rem_q;
  assign quo_fix = q_neg_q ? -quo_q : quo_q;

  int_div_step #(
    .WIDTH(WIDTH),
    .STEP (STEP)
  ) u_step (
    .rem_i(rem_q),
    .quo_i(quo_q),
    .div_i(div_q),
    .rem_o(rem_nx),
    .quo_o(quo_nx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = (dbz || ovf || hit) ? S_DONE : S_CALC;
      S_CALC:  if (cnt_q == LAST_CNT) state_d = S_FIX;
      S_FIX:   state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    busy_tag  = (state_q == S_IDLE) ? '0 : tag_q;
    result    = res_q;
    out_tag   = tag_q;
    out_dbz   = dbz_q;
    out_ovf   = ovf_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q    <= '0;
      quo_q    <= '0;
      div_q    <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      tag_q    <= '0;
      rem_op_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      dbz_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (accept) begin
        tag_q    <= in_tag;
        rem_op_q <= is_rem_op(op);
        q_neg_q  <= a_neg ^ b_neg;
        r_neg_q  <= a_neg;
        rem_q    <= '0;
        quo_q    <= a_abs;
        div_q    <= b_abs;
        cnt_q    <= '0;
        dbz_q    <= dbz;
        ovf_q    <= ovf;
        if (dbz)      res_q <= is_rem_op(op) ? a : '1;
        else if (ovf) res_q <= is_rem_op(op) ? '0 : INT_MIN_C;
        else if (hit) res_q <= hit_res;
      end
      if (state_q == S_CALC) begin
        rem_q <= rem_nx;
        quo_q <= quo_nx;
        cnt_q <= cnt_q + 1'b1;
      end
      if (state_q == S_FIX) res_q <= rem_op_q ? rem_fix : quo_fix;
    end
  end

`ifdef INT_DIV_RESULT_CACHE_EN
  logic             cache_vld_q, cache_sgn_q, sgn_q;
  logic [WIDTH-1:0] cache_a_q, cache_b_q, cache_quo_q, cache_rem_q, op_a_q, op_b_q;

  assign hit = cache_vld_q && (cache_a_q == a) && (cache_b_q == b) &&
               (cache_sgn_q == is_signed_op(op));
  assign hit_res = is_rem_op(op) ? cache_rem_q : cache_quo_q;

  // Both quotient and remainder are captured so either op can hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cache_vld_q <= 1'b0;
      cache_sgn_q <= 1'b0;
      sgn_q       <= 1'b0;
      cache_a_q   <= '0;
      cache_b_q   <= '0;
      cache_quo_q <= '0;
      cache_rem_q <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
    end else begin
      if (accept) begin
        op_a_q <= a;
        op_b_q <= b;
        sgn_q  <= is_signed_op(op);
      end
      if (state_q == S_FIX) begin
        cache_vld_q <= 1'b1;
        cache_a_q   <= op_a_q;
        cache_b_q   <= op_b_q;
        cache_sgn_q <= sgn_q;
        cache_quo_q <= quo_fix;
        cache_rem_q <= rem_fix;
      end
      if (flush) cache_vld_q <= 1'b0;
    end
  end
`else
  assign hit     = 1'b0;
  assign hit_res = '0;
`endif

endmodule

// File: doc/int_div_rem_mc.md
INT_DIV_REM_MC -- requirements
Module: int_div_rem_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have parameter STEP, default 1, quotient bits retired per cycle (1, 2 or 4).
REQ-003 SHALL have parameter TAG_W, default 5, width of destination tag (rd).
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port clk  in  1  rising-edge clock.
REQ-006 SHALL have port rst  in  1  asynchronous active-high reset.
REQ-007 SHALL have port flush  in  1  synchronous kill of any in-flight or pending operation.
REQ-008 SHALL have port in_valid  in  1  request present.
REQ-009 SHALL have port in_ready  out  1  unit can accept.
REQ-010 SHALL have port op  in  2  div_op_t: DIV, DIVU, REM, REMU.
REQ-011 SHALL have port a  in  WIDTH  dividend.
REQ-012 SHALL have port b  in  WIDTH  divisor.
REQ-013 SHALL have port in_tag  in  TAG_W  destination tag.
REQ-014 SHALL have port out_valid  out  1  result present, held until taken.
REQ-015 SHALL have port out_ready  in  1  consumer takes result.
REQ-016 SHALL have port result  out  WIDTH  quotient or remainder.
REQ-017 SHALL have port out_tag  out  TAG_W  tag of result.
REQ-018 SHALL have port out_dbz  out  1  divisor was zero.
REQ-019 SHALL have port out_ovf  out  1  signed overflow (INT_MIN / -1).
REQ-020 SHALL have port busy_tag  out  TAG_W  tag in flight, 0 when IDLE (hazard check).

Function
REQ-021 SHALL implement states IDLE, CALC, FIX, DONE; in_ready=1 only in IDLE.
REQ-022 Accept SHALL occur on in_valid&in_ready; it registers a, b, op and in_tag and computes operand absolute values for DIV/REM.
REQ-023 Normal path: IDLE->CALC; CALC SHALL last N=WIDTH/STEP cycles and retire STEP restoring-division bits per cycle; CALC->FIX after N cycles, then FIX->DONE.
REQ-024 FIX SHALL apply signs: quotient negated if operand signs differ (signed ops); remainder takes the dividend's sign.
REQ-025 out_valid SHALL assert exactly N+2 cycles after the accept cycle (34 for WIDTH=32, STEP=1).
REQ-026 b==0 SHALL go IDLE->DONE, giving out_valid 1 cycle after accept, out_dbz=1, result all-ones for DIV/DIVU and a for REM/REMU.
REQ-027 Signed a==INT_MIN with b==-1 SHALL go IDLE->DONE, giving out_valid 1 cycle after accept, out_ovf=1, result INT_MIN for DIV and 0 for REM.
REQ-028 DONE SHALL hold result, out_tag and flags stable until out_ready; the handshake cycle returns to IDLE; no back-to-back accept in the same cycle.
REQ-029 flush SHALL force IDLE next cycle from any state and drop out_valid; flush with in_valid SHALL not accept.
REQ-030 STEP not dividing WIDTH SHALL be a elaboration-time error.

Reset
REQ-031 On rst, state=IDLE, in_ready=1, out_valid=0, result=0, out_tag=0, out_dbz=0, out_ovf=0 and busy_tag=0, immediately and asynchronously.
REQ-032 Reset asserted mid-CALC SHALL discard the operation with no out_valid after release.

Configuration
REQ-033 Macro INT_DIV_RESULT_CACHE_EN defined SHALL keep last quotient and remainder with operands and signedness; a request matching them SHALL go IDLE->DONE with out_valid 1 cycle after accept.
REQ-034 Macro undefined SHALL give no cache storage, with every request taking the REQ-025 latency; flush and rst SHALL invalidate the cache.

Structure
REQ-035 div_op_t and the INT_MIN constant function SHALL reside in riscv_types.
REQ-036 One sub-module, int_div_step, SHALL implement one STEP-bit combinational restoring iteration and is instantiated once.

Verification
REQ-037 DIV a=-7, b=2 -> result 0xFFFFFFFD, out_valid 34 cycles after accept; REM same operands -> 0xFFFFFFFF.
REQ-038 DIVU a=0xFFFFFFFF, b=0 -> result 0xFFFFFFFF, out_dbz=1, 1-cycle latency; REMU same operands -> 0xFFFFFFFF.
REQ-039 DIV a=0x80000000, b=0xFFFFFFFF -> result 0x80000000, out_ovf=1; REM same operands -> 0.
REQ-040 out_ready low 10 cycles in DONE -> result, out_tag stable, in_ready=0; flush at CALC cycle 5 -> IDLE next cycle, no out_valid.
REQ-041 STEP=4, DIVU 100/7 -> result 14, out_valid 10 cycles after accept; with cache, REMU 100/7 next -> result 2, 1-cycle latency.
REQ-042 rst pulse mid-CALC -> all outputs at reset values that cycle, in_ready=1 after release.
